// File: rtl/edge_pkg.sv
// edge_pkg: shared mode encodings and debounce counter sizing for edge_detector_multi.
package edge_pkg;
   localparam logic [1:0] MODE_OFF  = 2'b00;
   localparam logic [1:0] MODE_RISE = 2'b01;
   localparam logic [1:0] MODE_FALL = 2'b10;
   localparam logic [1:0] MODE_BOTH = 2'b11;
   function automatic int cnt_width(input int debounce_cycles);
      return (debounce_cycles <= 2) ? 1 : $clog2(debounce_cycles);
   endfunction
endpackage

// File: rtl/edge_channel.sv
// edge_channel: one input line -- synchroniser, debounce filter, edge classifier, sticky flag.
// Ports: clk, rst (async, active-high); signal raw input; mode {fall_en, rise_en};
//        clr sticky clear; out one-cycle edge pulse; level debounced level;
//        pending sticky flag; pending_next next-state of pending for the top-level OR register.
module edge_channel
   import edge_pkg::*;
#(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       signal,
   input  logic [1:0] mode,
   input  logic       clr,
   output logic       out,
   output logic       level,
   output logic       pending,
   output logic       pending_next
);
   localparam int CW = cnt_width(DEBOUNCE_CYCLES);
   logic [SYNC_STAGES-1:0] sh;
   logic [CW-1:0]          cnt;
   logic                   sync, accept, hit;
   assign sync = sh[SYNC_STAGES-1];
   // The new value has differed from level for DEBOUNCE_CYCLES consecutive cycles.
   assign accept = (sync != level) && (cnt == CW'(DEBOUNCE_CYCLES - 1));
   // sync is the level being accepted: 1 means a rise, 0 a fall.
   assign hit = accept && (sync ? mode[0] : mode[1]);
   // Set wins over a simultaneous clear.
   assign pending_next = hit || (pending && !clr);
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sh      <= '0;
         cnt     <= '0;
         level   <= 1'b0;
         out     <= 1'b0;
         pending <= 1'b0;
      end else begin
         sh      <= {sh[SYNC_STAGES-2:0], signal};
         cnt     <= (sync == level || accept) ? '0 : cnt + 1'b1;
         level   <= accept ? sync : level;
         out     <= hit;
         pending <= pending_next;
      end
   end
endmodule

// File: rtl/edge_detector_multi.sv
// edge_detector_multi: CHANNELS independent synchronised, debounced, mode-selected edge detectors.
// Ports: clk, rst (async, active-high); signal raw inputs; mode 2 bits per channel
//        (00 off, 01 rise, 10 fall, 11 both); clr per-channel sticky clear;
//        out edge pulses; level debounced levels; pending sticky flags;
//        any_pending registered OR of pending.
module edge_detector_multi
   import edge_pkg::*;
#(
   parameter int CHANNELS        = 4,
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [CHANNELS-1:0]   signal,
   input  logic [2*CHANNELS-1:0] mode,
   input  logic [CHANNELS-1:0]   clr,
   output logic [CHANNELS-1:0]   out,
   output logic [CHANNELS-1:0]   level,
   output logic [CHANNELS-1:0]   pending,
   output logic                  any_pending
);
   logic [CHANNELS-1:0] pending_next;
   for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      edge_channel #(
         .SYNC_STAGES    (SYNC_STAGES),
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_ch (
         .clk         (clk),
         .rst         (rst),
         .signal      (signal[i]),
         .mode        (mode[2*i +: 2]),
         .clr         (clr[i]),
         .out         (out[i]),
         .level       (level[i]),
         .pending     (pending[i]),
         .pending_next(pending_next[i])
      );
   end
   // Registered from the next-state so it lines up with pending.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) any_pending <= 1'b0;
      else     any_pending <= |pending_next;
   end
endmodule

// File: tb/tb_edge_detector_multi.sv
// tb_edge_detector_multi: directed and random checks of two instances (DEBOUNCE_CYCLES 1 and 4) against a history-based model.
module tb_edge_detector_multi;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] sig = '0;
   logic [3:0] clr = '0;
   logic [7:0] mode = '0;
   logic [3:0] oa, la, pa, ob, lb, pb;
   logic       ana, anb;
   int tests = 0;
   int fails = 0;
   int cnt_a[4];
   int cnt_b[4];
   int dd[2] = '{1, 4};
   logic [15:0] rawh[2][4];
   logic [15:0] synh[2][4];
   logic ml[2][4];
   logic mo[2][4];
   logic mp[2][4];

   edge_detector_multi #(.CHANNELS(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(1)) dut_a (
      .clk(clk), .rst(rst), .signal(sig), .mode(mode), .clr(clr),
      .out(oa), .level(la), .pending(pa), .any_pending(ana));
   edge_detector_multi #(.CHANNELS(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4)) dut_b (
      .clk(clk), .rst(rst), .signal(sig), .mode(mode), .clr(clr),
      .out(ob), .level(lb), .pending(pb), .any_pending(anb));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      for (int u = 0; u < 2; u++)
         for (int c = 0; c < 4; c++) begin
            rawh[u][c] = '0; synh[u][c] = '0;
            ml[u][c] = 1'b0; mo[u][c] = 1'b0; mp[u][c] = 1'b0;
         end
   endtask

   // Level flips once the last D synchronised samples all disagree with it;
   // the synchronised value is the raw input sampled one edge earlier.
   task automatic model_step();
      if (rst) begin
         model_reset();
         return;
      end
      for (int u = 0; u < 2; u++)
         for (int c = 0; c < 4; c++) begin
            logic flip;
            flip = 1'b1;
            for (int k = 0; k < dd[u]; k++)
               if (synh[u][c][k] == ml[u][c]) flip = 1'b0;
            mo[u][c] = flip && (ml[u][c] ? mode[2*c+1] : mode[2*c]);
            if (flip) ml[u][c] = ~ml[u][c];
            mp[u][c] = mo[u][c] || (mp[u][c] && !clr[c]);
            rawh[u][c] = {rawh[u][c][14:0], sig[c]};
            synh[u][c] = {synh[u][c][14:0], rawh[u][c][1]};
         end
   endtask

   task automatic check();
      logic [3:0] eo[2], el[2], ep[2];
      for (int u = 0; u < 2; u++)
         for (int c = 0; c < 4; c++) begin
            eo[u][c] = mo[u][c]; el[u][c] = ml[u][c]; ep[u][c] = mp[u][c];
         end
      chk("out_a", 32'(oa), 32'(eo[0]));
      chk("level_a", 32'(la), 32'(el[0]));
      chk("pending_a", 32'(pa), 32'(ep[0]));
      chk("any_pending_a", 32'(ana), 32'(|ep[0]));
      chk("out_b", 32'(ob), 32'(eo[1]));
      chk("level_b", 32'(lb), 32'(el[1]));
      chk("pending_b", 32'(pb), 32'(ep[1]));
      chk("any_pending_b", 32'(anb), 32'(|ep[1]));
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      check();
      for (int c = 0; c < 4; c++) begin
         cnt_a[c] += int'(oa[c]);
         cnt_b[c] += int'(ob[c]);
      end
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic clear_counts();
      for (int c = 0; c < 4; c++) begin
         cnt_a[c] = 0; cnt_b[c] = 0;
      end
   endtask

   initial begin
      model_reset();
      clear_counts();
      // Reset state
      run(2);
      chk("reset_zero_a", 32'({oa, la, pa, ana}), 32'h0);
      rst = 1'b0;
      // Rising edge on channel 0, mode rise
      mode = 8'h01;
      sig = 4'b0001;
      tick();
      tick();
      chk("rise_early", 32'(oa), 32'h0);
      tick();
      chk("rise_out", 32'(oa), 32'b0001);
      chk("rise_level", 32'(la[0]), 32'h1);
      tick();
      chk("rise_out_end", 32'(oa), 32'h0);
      chk("rise_pending", 32'(pa), 32'b0001);
      chk("rise_any", 32'(ana), 32'h1);
      // Channel 1 both-edges, then fall-only
      mode = 8'b0000_1100;
      clear_counts();
      sig[1] = 1'b1; run(5); sig[1] = 1'b0; run(8);
      chk("both_pulses", 32'(cnt_a[1]), 32'd2);
      mode = 8'b0000_1000;
      clear_counts();
      sig[1] = 1'b1; run(5); sig[1] = 1'b0; run(8);
      chk("fall_only_pulses", 32'(cnt_a[1]), 32'd1);
      // Debounce on the 4-cycle instance, channel 0 rise
      mode = 8'h01;
      sig[0] = 1'b0; run(8);
      clear_counts();
      sig[0] = 1'b1; run(3); sig[0] = 1'b0; run(8);
      chk("glitch_b_pulses", 32'(cnt_b[0]), 32'd0);
      chk("glitch_b_level", 32'(lb[0]), 32'h0);
      chk("glitch_a_pulses", 32'(cnt_a[0]), 32'd1);
      clear_counts();
      sig[0] = 1'b1; run(6); sig[0] = 1'b0; run(8);
      chk("long_b_pulses", 32'(cnt_b[0]), 32'd1);
      clear_counts();
      for (int i = 0; i < 10; i++) begin
         sig[0] = ~sig[0]; tick();
      end
      sig[0] = 1'b0; run(8);
      chk("toggle_b_pulses", 32'(cnt_b[0]), 32'd0);
      // Sticky flag with coincident set/clear on channel 2
      mode = 8'b0001_0000;
      clr = 4'hF; tick(); clr = '0;
      sig[2] = 1'b1; run(4);
      chk("pend2_set", 32'(pa[2]), 32'h1);
      sig[2] = 1'b0; run(6);
      sig[2] = 1'b1; tick(); tick();
      clr[2] = 1'b1; tick(); clr = '0;
      chk("pend2_out", 32'(oa[2]), 32'h1);
      chk("pend2_set_wins", 32'(pa[2]), 32'h1);
      tick();
      chk("pend2_held", 32'(pa[2]), 32'h1);
      run(6);
      clr = 4'b0100; tick(); clr = '0;
      chk("pend_cleared", 32'(pa), 32'h0);
      chk("any_cleared", 32'(ana), 32'h0);
      // All channels together, then channel 3 off
      mode = 8'hFF;
      sig = '0; run(8);
      sig = 4'hF; tick(); tick(); tick();
      chk("all_rise", 32'(oa), 32'hF);
      sig = '0; run(8);
      mode = 8'h3F;
      sig = 4'hF; tick(); tick(); tick();
      chk("ch3_off_out", 32'(oa), 32'b0111);
      chk("ch3_off_level", 32'(la[3]), 32'h1);
      // Reset mid-debounce with inputs high
      sig = '0; run(8);
      sig = 4'hF; run(3);
      rst = 1'b1;
      model_reset();
      #1;
      check();
      tick();
      rst = 1'b0;
      tick(); tick();
      chk("post_rst_early", 32'(oa), 32'h0);
      tick();
      chk("post_rst_rise", 32'(oa), 32'b0111);
      run(6);
      // Random traffic
      for (int i = 0; i < 400; i++) begin
         if (i % 20 == 0) mode = 8'($urandom);
         for (int c = 0; c < 4; c++) begin
            if ($urandom_range(3) == 0) sig[c] = ~sig[c];
            clr[c] = ($urandom_range(7) == 0);
         end
         tick();
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
